// File: rtl/act_tx.sv
// rtl/act_tx.sv - activation burst transmitter feeding a PE activation FIFO datain port
// Supports standard val/rdy and pulse-handshake receivers; mode is latched per burst.
module act_tx #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  PELACT_Handshake_n,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  tx_cnt,
    input  logic                  src_val,
    output logic                  src_rdy,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  dout_val,
    input  logic                  dout_rdy,
    output logic [DATA_WIDTH-1:0] dout_data
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic                  mode_q, mode_d;
    logic [CNT_WIDTH-1:0]  fetch_cnt_q, fetch_cnt_d;
    logic [CNT_WIDTH-1:0]  tx_cnt_q, tx_cnt_d;
    logic                  dout_val_q, dout_val_d;
    logic [DATA_WIDTH-1:0] dout_data_q, dout_data_d;

    logic src_xfer;
    logic deliver;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            mode_q      <= 1'b0;
            fetch_cnt_q <= '0;
            tx_cnt_q    <= '0;
            dout_val_q  <= 1'b0;
            dout_data_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            fetch_cnt_q <= fetch_cnt_d;
            tx_cnt_q    <= tx_cnt_d;
            dout_val_q  <= dout_val_d;
            dout_data_q <= dout_data_d;
        end
    end

    // A pulse-mode receiver pushes on val alone, so the word is delivered the cycle it is shown.
    assign src_xfer = src_val && src_rdy;
    assign deliver  = dout_val_q && (mode_q || dout_rdy);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        mode_d      = mode_q;
        fetch_cnt_d = fetch_cnt_q;
        tx_cnt_d    = tx_cnt_q;
        dout_val_d  = dout_val_q;
        dout_data_d = dout_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d       = burst_len;
                    mode_d      = PELACT_Handshake_n;
                    fetch_cnt_d = '0;
                    tx_cnt_d    = '0;
                    state_d     = (burst_len != '0) ? SEND : DONE;
                end
            end
            SEND: begin
                if (deliver) begin
                    dout_val_d = 1'b0;
                    tx_cnt_d   = tx_cnt_q + 1'b1;
                end
                if (src_xfer) begin
                    dout_val_d  = 1'b1;
                    dout_data_d = src_data;
                    fetch_cnt_d = fetch_cnt_q + 1'b1;
                end
                if (tx_cnt_d == len_q && !dout_val_d) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == SEND) || (state_q == DONE);
        done    = (state_q == DONE);
        src_rdy = 1'b0;
        if (state_q == SEND && fetch_cnt_q < len_q) begin
            src_rdy = mode_q ? (!dout_val_q && dout_rdy) : (!dout_val_q || dout_rdy);
        end
    end

    assign dout_val  = dout_val_q;
    assign dout_data = dout_data_q;
    assign tx_cnt    = tx_cnt_q;

endmodule

// File: tb/tb_act_tx.sv
// tb/tb_act_tx.sv - scoreboard bench for act_tx covering both handshake modes
module tb_act_tx;

    logic        clk;
    logic        reset;
    logic        hs;
    logic        start;
    logic [9:0]  burst_len;
    logic        busy;
    logic        done;
    logic [9:0]  tx_cnt;
    logic        src_val;
    logic        src_rdy;
    logic [63:0] src_data;
    logic        dout_val;
    logic        dout_rdy;
    logic [63:0] dout_data;

    act_tx #(.DATA_WIDTH(64), .CNT_WIDTH(10)) dut (
        .clk(clk), .reset(reset), .PELACT_Handshake_n(hs), .start(start),
        .burst_len(burst_len), .busy(busy), .done(done), .tx_cnt(tx_cnt),
        .src_val(src_val), .src_rdy(src_rdy), .src_data(src_data),
        .dout_val(dout_val), .dout_rdy(dout_rdy), .dout_data(dout_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [63:0] src_words[$];
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int          deliv_cyc[$];
    int          src_idx;
    int          cyc = 0;
    int          done_cnt;
    int          done_cyc;
    bit          prev_val, prev_stall, adj, hold_bad, src_rdy_seen;
    logic [63:0] prev_data;

    task automatic begin_burst(input int n, input logic [63:0] base);
        src_words.delete(); exp_q.delete(); got_q.delete(); deliv_cyc.delete();
        src_idx = 0; done_cnt = 0; done_cyc = -1;
        prev_val = 0; prev_stall = 0; adj = 0; hold_bad = 0; src_rdy_seen = 0;
        for (int k = 0; k < n; k++) begin
            src_words.push_back(base + 64'(k));
            exp_q.push_back(base + 64'(k));
        end
    endtask

    // One cycle: drive inputs at posedge+1, observe at posedge+2, advance to next posedge+1.
    task automatic step(input bit sv, input bit rq, input bit pulse);
        src_val  = sv && (src_idx < src_words.size());
        src_data = (src_idx < src_words.size()) ? src_words[src_idx] : 64'h0;
        dout_rdy = pulse ? (rq && !dout_val) : rq;
        #1;
        if (dout_val && (pulse || dout_rdy)) begin
            got_q.push_back(dout_data);
            deliv_cyc.push_back(cyc);
        end
        if (pulse && dout_val && prev_val) adj = 1;
        if (prev_stall && (!dout_val || dout_data !== prev_data)) hold_bad = 1;
        prev_stall = !pulse && dout_val && !dout_rdy;
        prev_data  = dout_data;
        prev_val   = dout_val;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (src_rdy) src_rdy_seen = 1;
        if (src_val && src_rdy) src_idx++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_done(input bit pulse, input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            step(1, 1, pulse);
            if (done_cnt > 0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic kick(input int n, input bit mode, input bit pulse);
        burst_len = 10'(n);
        hs = mode;
        start = 1;
        step(0, 1, pulse);
        start = 0;
    endtask

    task automatic test_reset;
        reset = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if ({busy, done, src_rdy, dout_val} !== 4'b0)
            $display("FAIL reset_flags got=%b want=0000", {busy, done, src_rdy, dout_val});
        else total += 0;
        if ({busy, done, src_rdy, dout_val} !== 4'b0) bad++;
        total++;
        if (dout_data !== 64'h0) begin bad++; $display("FAIL reset_data got=%h want=0", dout_data); end
        total++;
        if (tx_cnt !== 10'd0) begin bad++; $display("FAIL reset_tx_cnt got=%0d want=0", tx_cnt); end
        reset = 0;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic test_mode0_basic;
        int t; bit ok; logic [63:0] e, g; int k;
        begin_burst(4, 64'hA0);
        t = cyc;
        kick(4, 0, 0);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL m0_busy_t1 got=%b want=1", busy); end
        wait_done(0, 40, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL m0_timeout got=no_done want=done"); end
        total++;
        if (got_q.size() != 4) begin bad++; $display("FAIL m0_count got=%0d want=4", got_q.size()); end
        k = 0;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL m0_data[%0d] got=%h want=%h", k, g, e); end
            total++;
            if (deliv_cyc[k] != t + 2 + k) begin
                bad++; $display("FAIL m0_cycle[%0d] got=%0d want=%0d", k, deliv_cyc[k] - t, 2 + k);
            end
            k++;
        end
        total++;
        if (done_cyc != t + 6) begin bad++; $display("FAIL m0_done_cycle got=%0d want=6", done_cyc - t); end
        total++;
        if (tx_cnt !== 10'd4) begin bad++; $display("FAIL m0_tx_cnt got=%0d want=4", tx_cnt); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL m0_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_mode0_stall;
        logic [63:0] e, g; int k;
        begin_burst(3, 64'hB0);
        kick(3, 0, 0);
        for (int i = 0; i < 40 && done_cnt == 0; i++)
            step(i % 2 == 0, !(i == 3 || i == 4), 0);
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL stall_done got=%0d want=1", done_cnt); end
        total++;
        if (got_q.size() != 3) begin bad++; $display("FAIL stall_count got=%0d want=3", got_q.size()); end
        total++;
        if (hold_bad) begin bad++; $display("FAIL stall_hold got=unstable want=stable"); end
        if (deliv_cyc.size() == 3) begin
            total++;
            if (done_cyc != deliv_cyc[2] + 1)
                begin bad++; $display("FAIL stall_done_lat got=%0d want=1", done_cyc - deliv_cyc[2]); end
        end
        k = 0;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL stall_data[%0d] got=%h want=%h", k, g, e); end
            k++;
        end
        total++;
        if (tx_cnt !== 10'd3) begin bad++; $display("FAIL stall_tx_cnt got=%0d want=3", tx_cnt); end
    endtask

    task automatic test_mode1_full;
        logic [63:0] e, g; int k;
        begin_burst(3, 64'h1C0);
        kick(3, 1, 1);
        hs = 0;
        for (int i = 0; i < 40 && done_cnt == 0; i++)
            step(1, !(i >= 2 && i <= 6), 1);
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL m1_done got=%0d want=1", done_cnt); end
        total++;
        if (adj) begin bad++; $display("FAIL m1_adjacent_val got=1 want=0"); end
        total++;
        if (got_q.size() != 3) begin bad++; $display("FAIL m1_pushes got=%0d want=3", got_q.size()); end
        k = 0;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL m1_data[%0d] got=%h want=%h", k, g, e); end
            k++;
        end
        total++;
        if (tx_cnt !== 10'd3) begin bad++; $display("FAIL m1_tx_cnt got=%0d want=3", tx_cnt); end
    endtask

    task automatic test_mode_toggle;
        int t; bit ok; logic [63:0] e, g; int k;
        // latched pulse mode, pin dropped to 0 mid-burst
        begin_burst(3, 64'h2A0);
        t = cyc;
        kick(3, 1, 1);
        step(1, 1, 1);
        hs = 0;
        wait_done(1, 40, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL tog1_timeout got=no_done want=done"); end
        total++;
        if (done_cyc != t + 7) begin bad++; $display("FAIL tog1_done_cycle got=%0d want=7", done_cyc - t); end
        k = 0;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++;
            if (g !== e || deliv_cyc[k] != t + 2 + 2 * k) begin
                bad++;
                $display("FAIL tog1_word[%0d] got=%h@%0d want=%h@%0d", k, g, deliv_cyc[k] - t, e, 2 + 2 * k);
            end
            k++;
        end
        // latched val/rdy mode, pin raised to 1 mid-burst
        begin_burst(3, 64'h2B0);
        t = cyc;
        kick(3, 0, 0);
        hs = 1;
        wait_done(0, 40, ok);
        hs = 0;
        total++;
        if (done_cyc != t + 5) begin bad++; $display("FAIL tog0_done_cycle got=%0d want=5", done_cyc - t); end
        k = 0;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++;
            if (g !== e || deliv_cyc[k] != t + 2 + k) begin
                bad++;
                $display("FAIL tog0_word[%0d] got=%h@%0d want=%h@%0d", k, g, deliv_cyc[k] - t, e, 2 + k);
            end
            k++;
        end
    endtask

    task automatic test_zero_len;
        int t; bit ok;
        begin_burst(0, 64'h0);
        t = cyc;
        kick(0, 0, 0);
        wait_done(0, 10, ok);
        total++;
        if (done_cyc != t + 1) begin bad++; $display("FAIL zero_done_cycle got=%0d want=1", done_cyc - t); end
        total++;
        if (got_q.size() != 0) begin bad++; $display("FAIL zero_words got=%0d want=0", got_q.size()); end
        total++;
        if (src_rdy_seen) begin bad++; $display("FAIL zero_src_rdy got=1 want=0"); end
        total++;
        if (tx_cnt !== 10'd0) begin bad++; $display("FAIL zero_tx_cnt got=%0d want=0", tx_cnt); end
    endtask

    task automatic test_start_ignored;
        bit ok;
        begin_burst(3, 64'hC0);
        kick(3, 0, 0);
        step(1, 1, 0);
        burst_len = 10'd7;
        start = 1;
        step(1, 1, 0);
        start = 0;
        wait_done(0, 40, ok);
        total++;
        if (got_q.size() != 3) begin bad++; $display("FAIL ign_count got=%0d want=3", got_q.size()); end
        total++;
        if (tx_cnt !== 10'd3) begin bad++; $display("FAIL ign_tx_cnt got=%0d want=3", tx_cnt); end
        step(0, 1, 0);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL ign_idle got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid;
        bit ok; logic [63:0] e, g;
        begin_burst(2, 64'hD0);
        kick(2, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        reset = 1;
        step(0, 0, 0);
        total++;
        if ({busy, done, src_rdy, dout_val} !== 4'b0)
            begin bad++; $display("FAIL rst_mid_flags got=%b want=0000", {busy, done, src_rdy, dout_val}); end
        total++;
        if (dout_data !== 64'h0 || tx_cnt !== 10'd0)
            begin bad++; $display("FAIL rst_mid_regs got=%h/%0d want=0/0", dout_data, tx_cnt); end
        total++;
        if (done_cnt != 0) begin bad++; $display("FAIL rst_mid_done got=%0d want=0", done_cnt); end
        reset = 0;
        begin_burst(2, 64'hE0);
        kick(2, 0, 0);
        wait_done(0, 40, ok);
        total++;
        if (!ok || got_q.size() != 2)
            begin bad++; $display("FAIL rst_after_count got=%0d want=2", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL rst_after_data got=%h want=%h", g, e); end
        end
        total++;
        if (tx_cnt !== 10'd2) begin bad++; $display("FAIL rst_after_tx_cnt got=%0d want=2", tx_cnt); end
    endtask

    initial begin
        reset = 1; hs = 0; start = 0; burst_len = '0;
        src_val = 0; src_data = '0; dout_rdy = 0;
        test_reset();
        test_mode0_basic();
        test_mode0_stall();
        test_mode1_full();
        test_mode_toggle();
        test_zero_len();
        test_start_ignored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/act_tx.md
# act_tx

Activation transmitter that feeds one single-input activation buffer (the 1-write/2-read activation FIFO in each PE lane) over its `datain` val/rdy port. It pulls a programmed burst of words from an upstream stream and forwards them. It supports both buffer protocol modes: normal val/rdy and the pulse handshake selected by `PELACT_Handshake_n`. It sits between the activation global-buffer read path and the per-PE activation FIFO.

## Interface
Parameters:
- `DATA_WIDTH`, 64: activation word width; must match the receiving FIFO width.
- `CNT_WIDTH`, 10: width of the burst length and word counters.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `PELACT_Handshake_n` in 1: mode select. 0 = normal val/rdy; 1 = pulse handshake. Sampled at `start`.
- `start` in 1: one-cycle burst request.
- `burst_len` in CNT_WIDTH: number of words in the burst. Sampled at `start`.
- `busy` out 1: high from the cycle after an accepted `start` through the `done` cycle.
- `done` out 1: one-cycle pulse at burst completion.
- `tx_cnt` out CNT_WIDTH: words delivered in the current or last burst.
- `src_val` in 1, `src_rdy` out 1, `src_data` in DATA_WIDTH: upstream stream.
- `dout_val` out 1, `dout_rdy` in 1, `dout_data` out DATA_WIDTH: connect to the FIFO `datain_val`, `datain_rdy` and `datain`.

## Operation
- FSM states are IDLE, SEND and DONE.
- IDLE:
  - On `start` with `burst_len != 0`: latch `burst_len`, latch the mode into `mode_q`, clear `fetch_cnt` and `tx_cnt`, and go to SEND.
  - On `start` with `burst_len == 0`: go to DONE and transfer no words.
- `start` is ignored in SEND and DONE.
- SEND contains a one-entry output register (`dout_data`/`dout_val`). An upstream transfer (`src_val && src_rdy`) loads it and increments `fetch_cnt`.
- Mode 0 (`mode_q == 0`), standard val/rdy:
  - `src_rdy = SEND && fetch_cnt < len && (!dout_val || dout_rdy)`. This is combinational on `dout_rdy`.
  - A delivery is `dout_val && dout_rdy`, and it increments `tx_cnt`.
  - `dout_val` and `dout_data` hold stable until the word is accepted.
- Mode 1 (`mode_q == 1`), pulse handshake: the receiver drops `rdy` whenever `val` is high and pushes on `val` alone.
  - `src_rdy = SEND && fetch_cnt < len && !dout_val && dout_rdy`.
  - A loaded word drives `dout_val` for exactly one cycle. It counts as delivered in that cycle regardless of `dout_rdy`.
  - `dout_val` never stays high for two consecutive cycles.
  - This is safe because the receiver's fill level cannot grow between sampling `rdy` and the push.
- SEND → DONE when `tx_cnt` reaches `len` and the output register is empty.
- DONE: `done = 1` for one cycle, then go to IDLE. `tx_cnt` holds its final value until the next accepted `start`.
- `busy` = state is SEND or DONE.
- Counters never wrap; `fetch_cnt` never exceeds `len`.
- Reset mid-burst: the FSM returns to IDLE and any in-flight word is discarded (no `dout_val` on the following cycle). `done` is not pulsed.

## Timing
- On reset, all outputs are 0: `busy`, `done`, `src_rdy`, `dout_val`, `dout_data` and `tx_cnt`.
- Accepted `start` at cycle t: `busy` rises at t+1, and `src_rdy` may first assert at t+1.
- Mode 0 with `src_val = 1` and `dout_rdy = 1` throughout:
  - `dout_val` is high from t+2 to t+N+1, one word per cycle.
  - `done` pulses at t+N+2; IDLE at t+N+3.
- Mode 1 with `src_val = 1` and receiver not full:
  - Word k (k = 0..N-1) has `dout_val` high at t+2+2k.
  - `done` pulses at t+2N+1.
- In both modes the latency from the last delivery to `done` is 1 cycle.
- Source data order is preserved. No word is duplicated or dropped.

## Test plan
- Mode 0, N=4, `src_data` = 0xA0..0xA3, no stalls → `dout_data` shows A0, A1, A2, A3 at t+2..t+5; `done` at t+6; `tx_cnt` = 4.
- Mode 0, N=3, `dout_rdy` low for 2 cycles mid-burst and `src_val` toggling → each word is held stable while stalled, order is preserved, exactly 3 deliveries occur, and `done` is 1 cycle after the last delivery.
- Mode 1, N=3, connected to the real activation FIFO held full for 5 cycles → `dout_val` is never high on adjacent cycles, FIFO receives 3 pushes in order, and `done` pulses.
- `burst_len` = 0 → `done` at t+1 with no `dout_val` or `src_rdy`; a `start` pulsed during `busy` is ignored and `tx_cnt` is unchanged.
- `reset` asserted while SEND holds a loaded word → next cycle all outputs are 0 and the FSM is IDLE; a new N=2 burst then completes normally.
- `PELACT_Handshake_n` toggled mid-burst → the burst continues in the mode latched at `start`.
